// File: rtl/seg_msg_sequencer.sv
// Seven-segment message sequencer: buffers glyph codes, then plays them one per display slot.
// Optional macro SEG_MSG_GAP_EN inserts a blank slot between glyphs.
module seg_msg_sequencer #(
   parameter int DEPTH    = 8,
   parameter int TICK_DIV = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_data,
   input  logic       start,
   input  logic       loop,
   input  logic       clear,
   output logic [7:0] seg_out,
   output logic       busy,
   output logic       done,
   output logic       full,
   output logic [1:0] state_dbg
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = IW + 1;
   localparam int PW = $clog2(TICK_DIV);
`ifdef SEG_MSG_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] count, count_nx;
   logic [IW-1:0] index, index_nx, index_inc;
   logic [PW-1:0] presc, presc_nx;
   logic [7:0]    seg_nx;
   logic          done_nx, wr_fire, slot_end, last;
   logic [3:0]    mem [DEPTH];

   function automatic logic [7:0] glyph(input logic [3:0] code);
      logic [7:0] pat;
      case (code)
         4'd1:    pat = 8'h89;
         4'd2:    pat = 8'h86;
         4'd3:    pat = 8'hC7;
         4'd4:    pat = 8'hC0;
         4'd5:    pat = 8'h88;
         4'd6:    pat = 8'h92;
         4'd7:    pat = 8'hCF;
         4'd8:    pat = 8'hC6;
         default: pat = 8'hFF;
      endcase
      return pat;
   endfunction

   // wr_en has no backpressure: a write is accepted only in IDLE while not full,
   // otherwise it is silently dropped; full is status, not a ready signal.
   assign full      = (count == CW'(DEPTH));
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign slot_end  = (presc == PW'(TICK_DIV - 1));
   assign last      = ({1'b0, index} == (count - CW'(1)));
   assign index_inc = last ? '0 : index + IW'(1);

   always_comb begin
      state_nx = state;
      count_nx = count;
      index_nx = index;
      presc_nx = presc;
      seg_nx   = seg_out;
      done_nx  = 1'b0;
      wr_fire  = 1'b0;
      if (clear) begin
         state_nx = IDLE;
         count_nx = '0;
         index_nx = '0;
         presc_nx = '0;
         seg_nx   = 8'hFF;
      end else begin
         case (state)
            IDLE: begin
               seg_nx   = 8'hFF;
               presc_nx = '0;
               if (start && (count != '0)) begin
                  state_nx = SHOW;
                  index_nx = '0;
                  seg_nx   = glyph(mem[0]);
               end else if (wr_en && !full) begin
                  wr_fire  = 1'b1;
                  count_nx = count + CW'(1);
               end
            end
            SHOW: begin
               presc_nx = slot_end ? '0 : presc + PW'(1);
               if (slot_end) begin
                  if (last && !loop) begin
                     state_nx = IDLE;
                     index_nx = '0;
                     seg_nx   = 8'hFF;
                     done_nx  = 1'b1;
                  end else if (GAP_EN) begin
                     state_nx = GAP;
                     seg_nx   = 8'hFF;
                  end else begin
                     state_nx = SHOW;
                     index_nx = index_inc;
                     seg_nx   = glyph(mem[index_inc]);
                  end
               end
            end
            GAP: begin
               // index still names the glyph just shown, so index_inc wraps after the last one
               presc_nx = slot_end ? '0 : presc + PW'(1);
               if (slot_end) begin
                  state_nx = SHOW;
                  index_nx = index_inc;
                  seg_nx   = glyph(mem[index_inc]);
               end
            end
            default: begin
               state_nx = IDLE;
               seg_nx   = 8'hFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         index   <= '0;
         presc   <= '0;
         seg_out <= 8'hFF;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         index   <= index_nx;
         presc   <= presc_nx;
         seg_out <= seg_nx;
         done    <= done_nx;
      end
   end

   // Storage is deliberately unreset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (!reset && wr_fire) begin
         mem[count[IW-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Randomized bench for seg_msg_sequencer with a slot-schedule reference model and scoreboard.
module tb_seg_msg_sequencer;
   localparam int DEPTH    = 8;
   localparam int TICK_DIV = 4;
`ifdef SEG_MSG_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   // clock / reset
   logic       clk = 1'b0;
   logic       reset, wr_en, start, loop, clear;
   logic [3:0] wr_data;
   logic [7:0] seg_out;
   logic       busy, done, full;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   seg_msg_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .start(start), .loop(loop), .clear(clear), .seg_out(seg_out),
      .busy(busy), .done(done), .full(full), .state_dbg(state_dbg)
   );

   // scoreboard: {seg_out, busy, done, full} expected after each edge
   logic [10:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   // reference model: message list plus a queue of slot patterns still to show
   logic [7:0] glyph_tab [16];
   logic [3:0] m_buf [DEPTH];
   int         m_count = 0;
   bit         m_play  = 1'b0;
   logic [7:0] m_cur   = 8'hFF;
   int         m_left  = 0;
   logic [7:0] m_sched[$];

   function automatic void build_pass();
      for (int i = 0; i < m_count; i++) begin
         if (i > 0 && GAP_EN) m_sched.push_back(8'hFF);
         m_sched.push_back(glyph_tab[m_buf[i]]);
      end
   endfunction

   function automatic void model_step(input logic w, input logic [3:0] d, input logic s,
                                      input logic l, input logic c, input logic r);
      logic dn;
      dn = 1'b0;
      if (r || c) begin
         m_count = 0;
         m_play  = 1'b0;
         m_sched.delete();
      end else if (!m_play) begin
         if (s && m_count > 0) begin
            m_sched.delete();
            build_pass();
            m_cur  = m_sched.pop_front();
            m_left = TICK_DIV;
            m_play = 1'b1;
         end else if (w && m_count < DEPTH) begin
            m_buf[m_count] = d;
            m_count++;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            if (m_sched.size() == 0) begin
               if (l) begin
                  if (GAP_EN) m_sched.push_back(8'hFF);
                  build_pass();
               end else begin
                  m_play = 1'b0;
                  dn     = 1'b1;
               end
            end
            if (m_play) begin
               m_cur  = m_sched.pop_front();
               m_left = TICK_DIV;
            end
         end
      end
      exp_q.push_back({(m_play ? m_cur : 8'hFF), m_play, dn, (m_count == DEPTH)});
   endfunction

   // driver tasks
   task automatic step(input logic w, input logic [3:0] d, input logic s,
                       input logic l, input logic c, input logic r);
      @(negedge clk);
      wr_en = w; wr_data = d; start = s; loop = l; clear = c; reset = r;
      model_step(w, d, s, l, c, r);
   endtask

   task automatic run(input int n, input logic l);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, l, 1'b0, 1'b0);
   endtask

   task automatic write_glyph(input logic [3:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // monitor
   initial begin
      logic [10:0] exp_v, got_v;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {seg_out, busy, done, full};
            total++;
            if (got_v !== exp_v) begin
               bad++;
               $display("FAIL trace t=%0t got seg=%h busy=%b done=%b full=%b want seg=%h busy=%b done=%b full=%b",
                        $time, got_v[10:3], got_v[2], got_v[1], got_v[0],
                        exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
         end
      end
   end

   // stimulus
   initial begin
      glyph_tab = '{8'hFF, 8'h89, 8'h86, 8'hC7, 8'hC0, 8'h88, 8'h92, 8'hCF,
                    8'hC6, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      reset = 1'b1; wr_en = 1'b0; wr_data = 4'd0; start = 1'b0; loop = 1'b0; clear = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // start with empty buffer
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(2, 1'b0);

      // HELLO, single pass
      write_glyph(4'd1); write_glyph(4'd2); write_glyph(4'd3); write_glyph(4'd3); write_glyph(4'd4);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(45, 1'b0);

      // replay with start+wr_en together, then clear mid-playback
      step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      run(9, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(2, 1'b0);

      // overfill: nine writes, playback of eight
      for (int i = 0; i < 9; i++) write_glyph(4'($urandom_range(0, 15)));
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(70, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // ASIC looping, then let it finish
      write_glyph(4'd5); write_glyph(4'd6); write_glyph(4'd7); write_glyph(4'd8);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      run(40, 1'b1);
      run(40, 1'b0);

      // reset during playback (gap slot when gaps enabled), then new message
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      run(5, 1'b1);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      write_glyph(4'd8); write_glyph(4'd4);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run(20, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(logic'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
              logic'($urandom_range(0, 12) == 0), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 80) == 0), logic'($urandom_range(0, 200) == 0));
      end
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      run(2, 1'b0);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
